// File: rtl/riscv_boot_pkg.sv
// Shared encodings for the boot loader: FSM state codes, header length and checksum width.
package riscv_boot_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  localparam int HDR_BYTES = 4;
  localparam int CSUM_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_HDR   = ST_HDR,
    S_LOAD  = ST_LOAD,
    S_CHECK = ST_CHECK,
    S_RUN   = ST_RUN,
    S_ERROR = ST_ERROR
  } boot_state_e;

  function automatic logic is_busy(input boot_state_e s);
    return (s == S_HDR) || (s == S_LOAD) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/riscv_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU/status outputs of the boot loader.
interface riscv_boot_loader_if;

  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output load_start, rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );

  modport slave (
    input  load_start, rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );

endinterface

// File: rtl/boot_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_vld_o is combinational on the 4th byte
// so the caller can register the completed word on the same edge. clear_i discards a partial word.
module boot_word_packer
  import riscv_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic [31:0] word_o,
  output logic        word_vld_o
);

  localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The three earlier bytes sit in shift_q with the oldest in [7:0].
  assign word_o     = {byte_dat_i, shift_q};
  assign word_vld_o = byte_vld_i && !clear_i && (cnt_q == LAST_BYTE);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_vld_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_dat_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/riscv_boot_loader.sv
// Holds the CPU in reset, streams a length-prefixed image into instruction memory, checks an
// XOR checksum and releases the CPU. All outputs are registered from the next-state decode.
module riscv_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int          IMEM_DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  riscv_boot_loader_if.slave  bus
);

  localparam int IDX_W = $clog2(IMEM_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  boot_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  num_q, num_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [TMR_W-1:0]  tmr_inc;

  logic        rx_ready_q, rx_ready_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [31:0] pk_word;
  logic        pk_word_vld;
  logic        hdr_bad;

  // A restart in the same cycle as a byte drops the byte.
  assign accept  = bus.rx_valid && rx_ready_q && !bus.load_start;
  assign tmr_inc = tmr_q + TMR_W'(1);
  assign hdr_bad = (pk_word == 32'd0) || (pk_word > 32'(IMEM_DEPTH));

  boot_word_packer u_packer (
    .clk_i      (clk_i),
    .rst_ni     (reset_ni),
    .clear_i    (bus.load_start),
    .byte_vld_i (accept),
    .byte_dat_i (bus.rx_data),
    .word_o     (pk_word),
    .word_vld_o (pk_word_vld)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    csum_d       = csum_q;
    tmr_d        = tmr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (bus.load_start) begin
      state_d = S_HDR;
      idx_d   = '0;
      num_d   = '0;
      csum_d  = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        S_HDR, S_LOAD, S_CHECK: begin
          tmr_d = accept ? '0 : tmr_inc;
          case (state_q)
            S_HDR: begin
              if (pk_word_vld) begin
                if (hdr_bad) begin
                  state_d = S_ERROR;
                end else begin
                  num_d   = pk_word[IDX_W-1:0];
                  state_d = S_LOAD;
                end
              end
            end
            S_LOAD: begin
              if (accept) csum_d = csum_q ^ bus.rx_data;
              if (pk_word_vld) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                imem_wdata_d = pk_word;
                idx_d        = idx_q + IDX_W'(1);
                if ((idx_q + IDX_W'(1)) == num_q) state_d = S_CHECK;
              end
            end
            default: begin
              if (accept) state_d = (bus.rx_data == csum_q) ? S_RUN : S_ERROR;
            end
          endcase
          // An accepted byte always resets the timer, so it beats an expiring timeout.
          if (!accept && (tmr_inc == TMR_LIMIT)) state_d = S_ERROR;
        end
        S_IDLE, S_RUN, S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end

    rx_ready_d  = is_busy(state_d);
    busy_d      = is_busy(state_d);
    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      num_q        <= '0;
      csum_q       <= '0;
      tmr_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      csum_q       <= csum_d;
      tmr_q        <= tmr_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Scoreboarded bench for riscv_boot_loader: expected imem writes are queued as images are sent.
`timescale 1ns/1ps
module tb_riscv_boot_loader;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          TMO   = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_boot_loader_if bus ();

  riscv_boot_loader #(
    .IMEM_DEPTH     (DEPTH),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_we = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_e;
  logic [31:0] img[DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.imem_we === 1'b1) begin
      n_we++;
      if (sb_q.size() == 0) begin
        check("unexpected_imem_we", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("imem_addr", bus.imem_addr, sb_e[63:32]);
        check("imem_wdata", bus.imem_wdata, sb_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("rx_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Optionally presents a byte alongside load_start; it must be dropped.
  task automatic start(input logic with_byte);
    @(negedge clk);
    bus.load_start = 1'b1;
    if (with_byte) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h55;
    end
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
    check("start_cpu_reset", bus.cpu_reset, 32'd1);
    check("start_done", bus.done, 32'd0);
    check("start_busy", bus.busy, 32'd1);
  endtask

  task automatic load_image(input int n, input logic [7:0] csum_flip, input logic with_byte);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    start(with_byte);
    send_word(32'(n));
    for (int i = 0; i < n; i++) begin
      w = img[i];
      sb_q.push_back({BASE + 32'(4 * i), w});
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w);
    end
    send_byte(cs ^ csum_flip);
  endtask

  task automatic expect_status(input string tag, input logic done_e, input logic err_e);
    check({tag, "_done"}, bus.done, 32'(done_e));
    check({tag, "_error"}, bus.error, 32'(err_e));
    check({tag, "_cpu_reset"}, bus.cpu_reset, 32'(!done_e));
    check({tag, "_busy"}, bus.busy, 32'd0);
    check({tag, "_rx_ready"}, bus.rx_ready, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int we0;
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_imem_we", bus.imem_we, 32'd0);
    expect_status("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_status("idle", 1'b0, 1'b0);

    // Two-word image; checksum derived from the data bytes.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    load_image(2, 8'h00, 1'b0);
    expect_status("img2", 1'b1, 1'b0);
    check("img2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Restart from RUN with a full-depth image.
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    load_image(DEPTH, 8'h00, 1'b0);
    expect_status("full", 1'b1, 1'b0);
    check("full_sb_empty", 32'(sb_q.size()), 32'd0);

    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    load_image(2, 8'h01, 1'b0);
    expect_status("badcs", 1'b0, 1'b1);

    we0 = n_we;
    start(1'b0);
    send_word(32'd0);
    expect_status("n_zero", 1'b0, 1'b1);
    start(1'b0);
    send_word(32'(DEPTH + 1));
    expect_status("n_big", 1'b0, 1'b1);
    check("bad_hdr_no_we", 32'(n_we - we0), 32'd0);

    // Stall mid-word until the timer expires.
    start(1'b0);
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO - 1) @(posedge clk);
    #1 check("tmo_not_yet", bus.error, 32'd0);
    @(posedge clk);
    #1 expect_status("tmo", 1'b0, 1'b1);

    // A byte on the final allowed cycle keeps the load alive.
    start(1'b0);
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO - 1) @(posedge clk);
    send_byte(8'hCC);
    check("tmo_byte_wins", bus.error, 32'd0);
    sb_q.push_back({BASE, 32'hDDCC_BBAA});
    send_byte(8'hDD);
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
    expect_status("tmo_late", 1'b1, 1'b0);

    // Abort mid-word; restart carries a byte that must be dropped.
    start(1'b0);
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    img[0] = 32'hCAFE_F00D;
    load_image(1, 8'h00, 1'b1);
    expect_status("abort", 1'b1, 1'b0);

    // Asynchronous reset in the middle of a load.
    start(1'b0);
    send_word(32'd1);
    send_byte(8'h44);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cpu_reset", bus.cpu_reset, 32'd1);
    check("arst_busy", bus.busy, 32'd0);
    check("arst_rx_ready", bus.rx_ready, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_status("post_arst", 1'b0, 1'b0);

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
